ca90_iter_item_mem: RTL and testbench



---
 rtl/ca90_iter_item_mem_pkg.sv | 13 +
 rtl/ca90_unit.sv | 23 ++
 rtl/ca90_iter_item_mem.sv | 101 ++++++++++
 tb/tb_ca90_iter_item_mem.sv | 247 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ca90_iter_item_mem_pkg.sv
// Shared definitions for the sequential CA90 item-memory generator.
package ca90_iter_item_mem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ITER  = 2'd1,
    VALID = 2'd2
  } state_e;

  localparam int DefaultHVDimension = 512;
  localparam int DefaultNumItems    = 1024;

endpackage

// File: rtl/ca90_unit.sv
// Combinational CA90 step: each output bit is the XOR of its neighbours at
// distance shift_amt_i on a circular vector.
module ca90_unit #(
  parameter int Dimension  = 512,
  parameter int ShiftWidth = 1
) (
  input  logic [Dimension-1:0]  vector_i,
  input  logic [ShiftWidth-1:0] shift_amt_i,
  output logic [Dimension-1:0]  result_o
);

  logic [2*Dimension-1:0] dbl;
  logic [2*Dimension-1:0] rot_r;
  logic [2*Dimension-1:0] rot_l;

  // Doubling the vector turns both rotations into plain shifts.
  assign dbl   = {vector_i, vector_i};
  assign rot_r = dbl >> shift_amt_i;
  assign rot_l = dbl << shift_amt_i;

  assign result_o = rot_r[Dimension-1:0] ^ rot_l[2*Dimension-1:Dimension];

endmodule

// File: rtl/ca90_iter_item_mem.sv
// Item HV A = base HV after A CA90 steps, one step per clock, with the last
// result cached so non-decreasing addresses continue instead of restarting.
module ca90_iter_item_mem
  import ca90_iter_item_mem_pkg::*;
#(
  parameter int HVDimension = DefaultHVDimension,
  parameter int NumItems    = DefaultNumItems,
  parameter int AddrWidth   = $clog2(NumItems)
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic [HVDimension-1:0] base_hv_i,
  input  logic                   flush_i,
  input  logic [AddrWidth-1:0]   req_addr_i,
  input  logic                   req_valid_i,
  output logic                   req_ready_o,
  output logic [HVDimension-1:0] item_hv_o,
  output logic                   item_valid_o,
  input  logic                   item_ready_i
);

  if ((NumItems < 2) || ((NumItems & (NumItems - 1)) != 0)) begin : g_bad_num_items
    $error("NumItems must be a power of two and at least 2");
  end

  state_e                 state_q, state_d;
  logic [HVDimension-1:0] cur_hv_q, cur_hv_d;
  logic [AddrWidth-1:0]   cur_idx_q, cur_idx_d;
  logic [AddrWidth-1:0]   tgt_idx_q, tgt_idx_d;
  logic                   cache_valid_q, cache_valid_d;
  logic [HVDimension-1:0] step_hv;
  logic                   restart;

  ca90_unit #(
    .Dimension  (HVDimension),
    .ShiftWidth (1)
  ) u_ca90 (
    .vector_i    (cur_hv_q),
    .shift_amt_i (1'b1),
    .result_o    (step_hv)
  );

  // A flush or a backwards address cannot reuse the cached HV.
  assign restart = !cache_valid_q || flush_i || (req_addr_i < cur_idx_q);

  always_comb begin
    state_d       = state_q;
    cur_hv_d      = cur_hv_q;
    cur_idx_d     = cur_idx_q;
    tgt_idx_d     = tgt_idx_q;
    cache_valid_d = flush_i ? 1'b0 : cache_valid_q;
    req_ready_o   = 1'b0;
    item_valid_o  = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready_o = 1'b1;
        if (req_valid_i) begin
          state_d       = ITER;
          tgt_idx_d     = req_addr_i;
          cache_valid_d = 1'b1;
          if (restart) begin
            cur_hv_d  = base_hv_i;
            cur_idx_d = '0;
          end
        end
      end
      ITER: begin
        if (cur_idx_q == tgt_idx_q) begin
          state_d = VALID;
        end else begin
          cur_hv_d  = step_hv;
          cur_idx_d = cur_idx_q + AddrWidth'(1);
        end
      end
      VALID: begin
        item_valid_o = 1'b1;
        if (item_ready_i) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      cur_hv_q      <= '0;
      cur_idx_q     <= '0;
      tgt_idx_q     <= '0;
      cache_valid_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      cur_hv_q      <= cur_hv_d;
      cur_idx_q     <= cur_idx_d;
      tgt_idx_q     <= tgt_idx_d;
      cache_valid_q <= cache_valid_d;
    end
  end

  assign item_hv_o = cur_hv_q;

endmodule

// File: tb/tb_ca90_iter_item_mem.sv
// Directed bench for ca90_iter_item_mem at HVDimension = 8, NumItems = 16.
module tb_ca90_iter_item_mem;

  localparam int D  = 8;
  localparam int N  = 16;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_i = 1'b1;
  logic [D-1:0]  base_hv_i = 8'h01;
  logic          flush_i = 1'b0;
  logic [AW-1:0] req_addr_i = '0;
  logic          req_valid_i = 1'b0;
  logic          req_ready_o;
  logic [D-1:0]  item_hv_o;
  logic          item_valid_o;
  logic          item_ready_i = 1'b1;

  int tests_run    = 0;
  int tests_failed = 0;

  ca90_iter_item_mem #(
    .HVDimension (D),
    .NumItems    (N)
  ) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .base_hv_i    (base_hv_i),
    .flush_i      (flush_i),
    .req_addr_i   (req_addr_i),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .item_hv_o    (item_hv_o),
    .item_valid_o (item_valid_o),
    .item_ready_i (item_ready_i)
  );

  always #5 clk = ~clk;

  function automatic logic [D-1:0] ca90_ref(input logic [D-1:0] v, input int steps);
    logic [D-1:0] cur;
    logic [D-1:0] nxt;
    cur = v;
    for (int s = 0; s < steps; s++) begin
      for (int k = 0; k < D; k++) nxt[k] = cur[(k + 1) % D] ^ cur[(k + D - 1) % D];
      cur = nxt;
    end
    return cur;
  endfunction

  // All stimulus runs 1 time unit after a rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
  endtask

  // Issues one request and returns latency in edges counted from the accept
  // edge (-1 on timeout) plus the HV seen on the first valid cycle.
  task automatic run_request(input logic [AW-1:0] addr, output int lat, output logic [D-1:0] hv);
    req_addr_i  = addr;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    lat = 1;
    while (!item_valid_o && lat < 64) begin
      tick();
      lat++;
    end
    hv = item_hv_o;
    if (!item_valid_o) lat = -1;
    else if (item_ready_i) tick();
  endtask

  task automatic test_reset();
    apply_reset();
    tests_run++;
    if (req_ready_o !== 1'b1) begin
      tests_failed++; $display("FAIL reset_req_ready got=%b exp=1", req_ready_o);
    end
    tests_run++;
    if (item_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL reset_item_valid got=%b exp=0", item_valid_o);
    end
    tests_run++;
    if (item_hv_o !== 8'h00) begin
      tests_failed++; $display("FAIL reset_item_hv got=%h exp=00", item_hv_o);
    end
  endtask

  task automatic test_single_step();
    int lat; logic [D-1:0] hv;
    run_request(4'd1, lat, hv);
    tests_run++;
    if (hv !== 8'h82) begin
      tests_failed++; $display("FAIL a1_hv got=%h exp=82", hv);
    end
    tests_run++;
    if (lat !== 3) begin
      tests_failed++; $display("FAIL a1_latency got=%0d exp=3", lat);
    end
  endtask

  task automatic test_cache_repeat();
    int lat; logic [D-1:0] hv;
    apply_reset();
    run_request(4'd2, lat, hv);
    tests_run++;
    if (hv !== 8'h44 || lat !== 4) begin
      tests_failed++; $display("FAIL a2_first got hv=%h lat=%0d exp hv=44 lat=4", hv, lat);
    end
    run_request(4'd2, lat, hv);
    tests_run++;
    if (hv !== 8'h44 || lat !== 2) begin
      tests_failed++; $display("FAIL a2_repeat got hv=%h lat=%0d exp hv=44 lat=2", hv, lat);
    end
  endtask

  task automatic test_forward_and_restart();
    int lat; logic [D-1:0] hv;
    run_request(4'd5, lat, hv);
    tests_run++;
    if (hv !== ca90_ref(8'h01, 5) || lat !== 5) begin
      tests_failed++; $display("FAIL a5_hit got hv=%h lat=%0d exp hv=%h lat=5", hv, lat, ca90_ref(8'h01, 5));
    end
    run_request(4'd7, lat, hv);
    tests_run++;
    if (hv !== ca90_ref(8'h01, 7) || lat !== 4) begin
      tests_failed++; $display("FAIL a7_hit got hv=%h lat=%0d exp hv=%h lat=4", hv, lat, ca90_ref(8'h01, 7));
    end
    run_request(4'd3, lat, hv);
    tests_run++;
    if (hv !== 8'hAA || lat !== 5) begin
      tests_failed++; $display("FAIL a3_restart got hv=%h lat=%0d exp hv=aa lat=5", hv, lat);
    end
  endtask

  task automatic test_flush();
    int lat; logic [D-1:0] hv;
    // Cache sits at index 3, so A = 6 is a 3-step hit; flush lands mid-ITER.
    req_addr_i  = 4'd6;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    flush_i     = 1'b1;
    tick();
    flush_i = 1'b0;
    lat = 2;
    while (!item_valid_o && lat < 64) begin
      tick();
      lat++;
    end
    hv = item_hv_o;
    tests_run++;
    if (!item_valid_o || hv !== ca90_ref(8'h01, 6) || lat !== 5) begin
      tests_failed++; $display("FAIL flush_inflight got hv=%h lat=%0d exp hv=%h lat=5", hv, lat, ca90_ref(8'h01, 6));
    end
    tick();
    run_request(4'd6, lat, hv);
    tests_run++;
    if (hv !== ca90_ref(8'h01, 6) || lat !== 8) begin
      tests_failed++; $display("FAIL flush_restart got hv=%h lat=%0d exp hv=%h lat=8", hv, lat, ca90_ref(8'h01, 6));
    end
  endtask

  task automatic test_backpressure();
    int lat; logic [D-1:0] hv;
    item_ready_i = 1'b0;
    run_request(4'd2, lat, hv);
    tests_run++;
    if (hv !== 8'h44 || lat !== 4) begin
      tests_failed++; $display("FAIL bp_result got hv=%h lat=%0d exp hv=44 lat=4", hv, lat);
    end
    req_addr_i  = 4'd9;
    req_valid_i = 1'b1;
    for (int c = 0; c < 10; c++) begin
      tick();
      tests_run++;
      if (item_valid_o !== 1'b1 || item_hv_o !== 8'h44 || req_ready_o !== 1'b0) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d got valid=%b hv=%h rdy=%b exp valid=1 hv=44 rdy=0",
                 c, item_valid_o, item_hv_o, req_ready_o);
      end
    end
    req_valid_i  = 1'b0;
    item_ready_i = 1'b1;
    tick();
    tests_run++;
    if (req_ready_o !== 1'b1 || item_valid_o !== 1'b0) begin
      tests_failed++; $display("FAIL bp_release got rdy=%b valid=%b exp rdy=1 valid=0", req_ready_o, item_valid_o);
    end
    // Index 2 still cached: the held-off request for 9 never entered.
    run_request(4'd2, lat, hv);
    tests_run++;
    if (hv !== 8'h44 || lat !== 2) begin
      tests_failed++; $display("FAIL bp_ignored_req got hv=%h lat=%0d exp hv=44 lat=2", hv, lat);
    end
  endtask

  task automatic test_mid_reset();
    int lat; logic [D-1:0] hv;
    req_addr_i  = 4'd9;
    req_valid_i = 1'b1;
    tick();
    req_valid_i = 1'b0;
    tick();
    tick();
    apply_reset();
    tests_run++;
    if (req_ready_o !== 1'b1 || item_valid_o !== 1'b0 || item_hv_o !== 8'h00) begin
      tests_failed++;
      $display("FAIL midreset_outputs got rdy=%b valid=%b hv=%h exp rdy=1 valid=0 hv=00",
               req_ready_o, item_valid_o, item_hv_o);
    end
    // Cache invalid: A = 3 must restart from the new base even though 3 > 2.
    base_hv_i = 8'h0B;
    run_request(4'd3, lat, hv);
    tests_run++;
    if (hv !== ca90_ref(8'h0B, 3) || lat !== 5) begin
      tests_failed++; $display("FAIL midreset_restart got hv=%h lat=%0d exp hv=%h lat=5", hv, lat, ca90_ref(8'h0B, 3));
    end
    run_request(4'd4, lat, hv);
    tests_run++;
    if (hv !== ca90_ref(8'h0B, 4) || lat !== 3) begin
      tests_failed++; $display("FAIL newbase_hit got hv=%h lat=%0d exp hv=%h lat=3", hv, lat, ca90_ref(8'h0B, 4));
    end
  endtask

  initial begin
    #1;
    test_reset();
    test_single_step();
    test_cache_repeat();
    test_forward_and_restart();
    test_flush();
    test_backpressure();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
